// File: rtl/mul_share_pkg.sv
// Shared types and default sizes for mul_share_arbiter and its sub-modules.
package mul_share_pkg;

   localparam int DATA_LEN_DEF    = 32;
   localparam int MUL_LATENCY_DEF = 2;
   // Tag index is sized for the largest supported requester count (16).
   localparam int TAG_IDX_W       = 4;

   typedef enum logic [1:0] {
      SLOT_IDLE     = 2'd0,
      SLOT_INFLIGHT = 2'd1,
      SLOT_HOLD     = 2'd2
   } t_slot_state;

   typedef struct packed {
      logic                 valid;
      logic [TAG_IDX_W-1:0] index;
   } t_tag;

   localparam t_tag TAG_NONE = '{valid: 1'b0, index: {TAG_IDX_W{1'b0}}};

endpackage

// File: rtl/mul_share_arbiter_chk.sv
// Protocol checks for mul_share_arbiter: grant stays one-hot and a capture never lands on a held slot.
module mul_share_arbiter_chk #(
   parameter int N = 4
) (
   input logic         clk,
   input logic         reset,
   input logic [N-1:0] grant,
   input logic [N-1:0] capture,
   input logic [N-1:0] hold
);

   a_capture_not_hold: assert property (@(posedge clk) disable iff (reset)
      (capture & hold) == {N{1'b0}});

   a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
      $onehot0(grant));

endmodule

// File: rtl/mul_share_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant starting at a registered pointer.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);
   localparam int IDX_W = $clog2(N);
   localparam int SW    = IDX_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [SW-1:0]    sum_s, wrap_s;
   logic [IDX_W-1:0] cand_s;
   logic             hit_s, found_s;

   // First requesting index at or after the pointer, wrapping at N-1
   always_comb begin
      grant     = {N{1'b0}};
      grant_idx = {IDX_W{1'b0}};
      found_s   = 1'b0;
      sum_s     = {SW{1'b0}};
      wrap_s    = {SW{1'b0}};
      cand_s    = {IDX_W{1'b0}};
      hit_s     = 1'b0;
      for (int k = 0; k < N; k++) begin
         sum_s     = {1'b0, ptr_q} + SW'(k);
         wrap_s    = (sum_s >= SW'(N)) ? (sum_s - SW'(N)) : sum_s;
         cand_s    = wrap_s[IDX_W-1:0];
         hit_s     = ~found_s & req[cand_s];
         grant     = grant | ({N{hit_s}} & ({{(N-1){1'b0}}, 1'b1} << cand_s));
         grant_idx = hit_s ? cand_s : grant_idx;
         found_s   = found_s | hit_s;
      end
   end

   // Pointer moves past the winner only when a grant is taken
   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (grant_idx == LAST_IDX) ? {IDX_W{1'b0}} : (grant_idx + IDX_ONE);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= {IDX_W{1'b0}};
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one external pipelined multiplier among NUM_REQ requesters with round-robin issue.
// Optional event counters are built when MUL_SHARE_ARBITER_PERF_CNT_EN is defined.
module mul_share_arbiter
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_LEN    = DATA_LEN_DEF,
   parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_LEN-1:0]   req_a,
   input  logic [NUM_REQ*DATA_LEN-1:0]   req_b,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [NUM_REQ*DATA_LEN-1:0]   rsp_data,
   output logic [DATA_LEN-1:0]           mul_a,
   output logic [DATA_LEN-1:0]           mul_b,
   input  logic [DATA_LEN-1:0]           mul_result,
   output logic                          busy
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
   ,
   output logic [31:0]                   perf_issue_cnt,
   output logic [31:0]                   perf_stall_cnt,
   output logic [31:0]                   perf_hold_cnt
`endif
);
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int STAGES = MUL_LATENCY + 1;

   logic [NUM_REQ-1:0] idle_s, hold_s, capture_s, eligible_s, grant_s, not_idle_d_s;
   logic [IDX_W-1:0]   grant_idx_s;
   logic               issue_s;
   t_tag               tag_in_s, tag_out_s;
   t_tag [STAGES-1:0]  tag_q;
   logic [DATA_LEN-1:0] mul_a_q, mul_b_q;
   logic [NUM_REQ:0][DATA_LEN-1:0] chain_a_s, chain_b_s;
   logic               busy_q;

   assign eligible_s = req_valid & idle_s;
   assign issue_s    = |grant_s;
   assign req_ready  = grant_s;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .req       (eligible_s),
      .advance   (issue_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   // One-hot AND-OR operand mux; all-zero when nothing is granted.
   assign chain_a_s[0] = {DATA_LEN{1'b0}};
   assign chain_b_s[0] = {DATA_LEN{1'b0}};
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_mux
      assign chain_a_s[i+1] = chain_a_s[i] | (req_a[i*DATA_LEN +: DATA_LEN] & {DATA_LEN{grant_s[i]}});
      assign chain_b_s[i+1] = chain_b_s[i] | (req_b[i*DATA_LEN +: DATA_LEN] & {DATA_LEN{grant_s[i]}});
   end

   assign tag_in_s  = '{valid: issue_s, index: TAG_IDX_W'(grant_idx_s)};
   assign tag_out_s = tag_q[STAGES-1];

   // Operand registers, tag pipeline and busy flag
   always_ff @(posedge clk) begin
      if (reset) begin
         mul_a_q <= {DATA_LEN{1'b0}};
         mul_b_q <= {DATA_LEN{1'b0}};
         tag_q   <= {STAGES{TAG_NONE}};
         busy_q  <= 1'b0;
      end else begin
         mul_a_q <= chain_a_s[NUM_REQ];
         mul_b_q <= chain_b_s[NUM_REQ];
         tag_q   <= {tag_q[STAGES-2:0], tag_in_s};
         busy_q  <= |not_idle_d_s;
      end
   end

   assign mul_a = mul_a_q;
   assign mul_b = mul_b_q;
   assign busy  = busy_q;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      localparam logic [TAG_IDX_W-1:0] SLOT_ID = TAG_IDX_W'(i);
      t_slot_state         state_q, state_d;
      logic                rsp_valid_q;
      logic [DATA_LEN-1:0] data_q;

      assign capture_s[i]    = tag_out_s.valid & (tag_out_s.index == SLOT_ID);
      assign idle_s[i]       = (state_q == SLOT_IDLE);
      assign hold_s[i]       = (state_q == SLOT_HOLD);
      assign not_idle_d_s[i] = (state_d != SLOT_IDLE);
      assign rsp_valid[i]    = rsp_valid_q;
      assign rsp_data[i*DATA_LEN +: DATA_LEN] = data_q;

      // Slot next state: HOLD is exactly the response-valid state
      always_comb begin
         state_d = state_q;
         case (state_q)
            SLOT_IDLE:     state_d = grant_s[i]   ? SLOT_INFLIGHT : SLOT_IDLE;
            SLOT_INFLIGHT: state_d = capture_s[i] ? SLOT_HOLD     : SLOT_INFLIGHT;
            SLOT_HOLD:     state_d = rsp_ready[i] ? SLOT_IDLE     : SLOT_HOLD;
            default:       state_d = SLOT_IDLE;
         endcase
      end

      // Slot state and response registers
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q     <= SLOT_IDLE;
            rsp_valid_q <= 1'b0;
            data_q      <= {DATA_LEN{1'b0}};
         end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == SLOT_HOLD);
            data_q      <= (capture_s[i] && (state_q == SLOT_INFLIGHT)) ? mul_result : data_q;
         end
      end
   end

   mul_share_arbiter_chk #(.N(NUM_REQ)) u_chk (
      .clk     (clk),
      .reset   (reset),
      .grant   (grant_s),
      .capture (capture_s),
      .hold    (hold_s)
   );

`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
   logic [31:0] perf_issue_q, perf_stall_q, perf_hold_q;
   logic        stall_s, hold_wait_s;

   assign stall_s     = (|req_valid) & ~issue_s;
   assign hold_wait_s = |(hold_s & ~rsp_ready);

   // Event counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issue_q <= 32'd0;
         perf_stall_q <= 32'd0;
         perf_hold_q  <= 32'd0;
      end else begin
         perf_issue_q <= perf_issue_q + {31'd0, issue_s};
         perf_stall_q <= perf_stall_q + {31'd0, stall_s};
         perf_hold_q  <= perf_hold_q  + {31'd0, hold_wait_s};
      end
   end

   assign perf_issue_cnt = perf_issue_q;
   assign perf_stall_cnt = perf_stall_q;
   assign perf_hold_cnt  = perf_hold_q;
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed and random checks of mul_share_arbiter against a transaction-level reference model.
module tb_mul_share_arbiter;

   localparam int NR  = 4;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [127:0]  req_a, req_b, rsp_data;
   logic [31:0]   mul_a, mul_b, mul_result;
   logic          busy;
   logic [31:0]   p1 = 32'd0, p2 = 32'd0;
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
   logic [31:0]   perf_issue_cnt, perf_stall_cnt, perf_hold_cnt;
`endif

   int tests = 0;
   int fails = 0;

   // reference model state
   int          ptr;
   logic [3:0]  outst;
   int          due [NR];
   logic [31:0] exp_prod [NR];
   logic [31:0] exp_ma, exp_mb;
   int          cyc_n;
   logic [3:0]  last_ready;

   always #5 clk = ~clk;

   // two-cycle multiplier model
   always @(posedge clk) begin
      p1 <= mul_a * mul_b;
      p2 <= p1;
   end
   assign mul_result = p2;

   mul_share_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .busy       (busy)
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
      ,
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_hold_cnt  (perf_hold_cnt)
`endif
   );

   function automatic logic [31:0] slice(input logic [127:0] v, input int k);
      return 32'(v >> (k * 32));
   endfunction

   function automatic logic bit_of(input logic [3:0] v, input int k);
      return ((v >> k) & 4'b0001) != 4'b0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      ptr    = 0;
      outst  = 4'b0000;
      exp_ma = 32'd0;
      exp_mb = 32'd0;
   endtask

   task automatic do_reset(input int n);
      reset     = 1'b1;
      req_valid = 4'b0000;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   task automatic rnd_ops();
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // One clock: check outputs against the model at negedge, advance model, move past posedge.
   task automatic cyc();
      int g;
      logic [3:0] exp_rdy, exp_rv;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NR; k++) begin
         int j;
         j = (ptr + k) % NR;
         if (g < 0 && bit_of(req_valid, j) && !bit_of(outst, j)) g = j;
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      exp_rv  = 4'b0000;
      for (int i = 0; i < NR; i++)
         if (bit_of(outst, i) && cyc_n >= due[i]) exp_rv = exp_rv | (4'b0001 << i);
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("busy", 64'(busy), 64'(outst != 4'b0000));
      chk("mul_a", 64'(mul_a), 64'(exp_ma));
      chk("mul_b", 64'(mul_b), 64'(exp_mb));
      for (int i = 0; i < NR; i++)
         if (bit_of(exp_rv, i)) chk("rsp_data", 64'(slice(rsp_data, i)), 64'(exp_prod[i]));
      last_ready = req_ready;
      for (int i = 0; i < NR; i++)
         if (bit_of(exp_rv, i) && bit_of(rsp_ready, i)) outst = outst & ~(4'b0001 << i);
      if (g >= 0) begin
         outst       = outst | (4'b0001 << g);
         due[g]      = cyc_n + LAT + 2;
         exp_prod[g] = slice(req_a, g) * slice(req_b, g);
         exp_ma      = slice(req_a, g);
         exp_mb      = slice(req_b, g);
         ptr         = (g + 1) % NR;
      end else begin
         exp_ma = 32'd0;
         exp_mb = 32'd0;
      end
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] held;
      logic        seen;
      int          others, prev, idx, grants;
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
      logic [31:0] hold0;
`endif
      reset = 1'b1; req_valid = 4'b0000; rsp_ready = 4'b0000;
      req_a = 128'd0; req_b = 128'd0; cyc_n = 0; last_ready = 4'b0000;
      for (int i = 0; i < NR; i++) begin due[i] = 0; exp_prod[i] = 32'd0; end
      do_reset(3);

      // reset state
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data == 128'd0), 64'd1);
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_mul_b", 64'(mul_b), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // single request
      req_valid = 4'b0001; req_a = 128'd6; req_b = 128'd7;
      cyc();
      chk("single_ready", 64'(last_ready), 64'h1);
      req_valid = 4'b0000;
      for (int k = 1; k < 4; k++) begin
         chk("single_busy", 64'(busy), 64'd1);
         cyc();
      end
      chk("single_rv", 64'(rsp_valid), 64'h1);
      chk("single_data", 64'(slice(rsp_data, 0)), 64'd42);
      chk("single_busy4", 64'(busy), 64'd1);
      rsp_ready = 4'b0001;
      cyc();
      chk("single_idle", 64'(busy), 64'd0);

      // contention from a fresh pointer
      do_reset(2);
      rsp_ready = 4'b1111; req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) begin
         req_a[i*32 +: 32] = 32'(i + 1);
         req_b[i*32 +: 32] = 32'd10;
      end
      for (int k = 0; k < NR; k++) begin
         cyc();
         chk("cont_grant", 64'(last_ready), 64'(4'b0001 << k));
      end
      req_valid = 4'b0000;
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
      chk("perf_issue", 64'(perf_issue_cnt), 64'd4);
      chk("perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
      for (int k = 0; k < NR; k++) begin
         chk("cont_rv", 64'(rsp_valid), 64'(4'b0001 << k));
         chk("cont_data", 64'(slice(rsp_data, k)), 64'((k + 1) * 10));
         cyc();
      end

      // backpressure on requester 1
      rsp_ready = 4'b1101; req_valid = 4'b1111; seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         rnd_ops(); cyc(); seen = bit_of(rsp_valid, 1);
      end
      chk("bp_seen", 64'(seen), 64'd1);
      held = slice(rsp_data, 1); others = 0;
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
      hold0 = perf_hold_cnt;
`endif
      for (int k = 0; k < 10; k++) begin
         rnd_ops(); cyc();
         chk("bp_ready1", 64'(bit_of(last_ready, 1)), 64'd0);
         chk("bp_stable", 64'(slice(rsp_data, 1)), 64'(held));
         if ((last_ready & 4'b1101) != 4'b0000) others++;
      end
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
      chk("perf_hold", 64'(perf_hold_cnt - hold0), 64'd10);
`endif
      chk("bp_others", 64'(others > 0), 64'd1);
      rsp_ready = 4'b1111;
      cyc();
      chk("bp_hs_ready1", 64'(bit_of(last_ready, 1)), 64'd0);
      seen = 1'b0;
      for (int k = 0; k < NR && !seen; k++) begin
         rnd_ops(); cyc(); seen = bit_of(last_ready, 1);
      end
      chk("bp_regrant", 64'(seen), 64'd1);

      // fairness between requesters 0 and 2
      req_valid = 4'b0101; prev = -1; grants = 0;
      for (int k = 0; k < 40; k++) begin
         rnd_ops(); cyc();
         if (last_ready != 4'b0000) begin
            idx = (last_ready == 4'b0001) ? 0 : ((last_ready == 4'b0100) ? 2 : 9);
            if (prev >= 0) chk("fair_alt", 64'(idx), 64'(2 - prev));
            prev = idx; grants++;
         end
      end
      chk("fair_grants", 64'(grants >= 10), 64'd1);
      req_valid = 4'b0000;
      repeat (6) cyc();

      // product wraps to DATA_LEN bits
      req_valid = 4'b1000; req_a[96 +: 32] = 32'hFFFF_FFFF; req_b[96 +: 32] = 32'd2;
      cyc();
      chk("ovf_ready", 64'(last_ready), 64'h8);
      req_valid = 4'b0000;
      repeat (3) cyc();
      chk("ovf_rv", 64'(rsp_valid), 64'h8);
      chk("ovf_data", 64'(slice(rsp_data, 3)), 64'hFFFF_FFFE);
      cyc();

      // reset while a product is in flight
      do_reset(1);
      req_valid = 4'b0100; req_a[64 +: 32] = 32'd5; req_b[64 +: 32] = 32'd5;
      cyc();
      req_valid = 4'b0000;
      cyc();
      do_reset(1);
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("mid_rv", 64'(rsp_valid), 64'd0);
         chk("mid_data", 64'(rsp_data == 128'd0), 64'd1);
         chk("mid_busy", 64'(busy), 64'd0);
      end
      req_valid = 4'b0010; req_a[32 +: 32] = 32'd3; req_b[32 +: 32] = 32'd4;
      cyc();
      req_valid = 4'b0000;
      repeat (3) cyc();
      chk("post_rv", 64'(rsp_valid), 64'h2);
      chk("post_data", 64'(slice(rsp_data, 1)), 64'd12);
      cyc();

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         req_valid = 4'($urandom);
         rsp_ready = 4'($urandom);
         rnd_ops();
         cyc();
      end
      req_valid = 4'b0000; rsp_ready = 4'b1111;
      repeat (8) cyc();
      chk("drain_busy", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
